// File: rtl/frame_buffer.sv
// Double-buffered 1-bit-per-pixel framebuffer: the renderer fills the back bank while
// scanout reads the front bank, and the banks exchange every FRAMES_PER_SWAP frames.
module frame_buffer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int FRAMES_PER_SWAP   = 1,
    localparam int ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    input  logic                  frame_end,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data,
    output logic                  swap,
    output logic                  front_sel
);

    localparam int NUM_PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam int CNT_WIDTH  = $clog2(FRAMES_PER_SWAP + 1);
    localparam logic [ADDR_WIDTH:0]  PIX_LIMIT = (ADDR_WIDTH + 1)'(NUM_PIXELS);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(FRAMES_PER_SWAP - 1);

    logic                 bank0_q [NUM_PIXELS];
    logic                 bank1_q [NUM_PIXELS];
    logic                 rd_data_q;
    logic                 swap_q, swap_d;
    logic                 front_sel_q, front_sel_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wr_in_range;
    logic                 rd_in_range;

    // The limit is one bit wider than the address so a full power-of-two frame still fits.
    assign wr_in_range = {1'b0, wr_addr} < PIX_LIMIT;
    assign rd_in_range = {1'b0, rd_addr} < PIX_LIMIT;

    // Writes always target the bank that is not on screen; contents survive reset.
    always_ff @(posedge clk) begin
        if (ce && wr_en && wr_in_range) begin
            if (front_sel_q) begin
                bank0_q[wr_addr] <= wr_data;
            end else begin
                bank1_q[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 1'b0;
        end else if (ce && rd_en) begin
            if (!rd_in_range) begin
                rd_data_q <= 1'b0;
            end else if (front_sel_q) begin
                rd_data_q <= bank1_q[rd_addr];
            end else begin
                rd_data_q <= bank0_q[rd_addr];
            end
        end
    end

    // Swap is only raised by a counted frame_end, so it drops to zero on any other cycle.
    always_comb begin
        cnt_d       = cnt_q;
        front_sel_d = front_sel_q;
        swap_d      = 1'b0;
        if (ce && frame_end) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                front_sel_d = ~front_sel_q;
                swap_d      = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            swap_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            front_sel_q <= front_sel_d;
            swap_q      <= swap_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign swap      = swap_q;
    assign front_sel = front_sel_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: a pixel-array reference model predicts every cycle's
// outputs for a 4x3 instance (one frame per swap) and a second instance (three frames per swap).
module tb_frame_buffer;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NPIX = H * V;
    localparam int AW   = 4;

    logic          clk;
    logic          rst;
    logic          rst3;
    logic          ce;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic          wrData;
    logic          frameEnd;
    logic          frameEnd3;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic          rdData, swapOut, frontSel;
    logic          rdData3, swapOut3, frontSel3;

    frame_buffer #(
        .HOR_ACTIVE_PIXELS(H),
        .VER_ACTIVE_PIXELS(V),
        .FRAMES_PER_SWAP  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_data  (wrData),
        .frame_end(frameEnd),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .rd_data  (rdData),
        .swap     (swapOut),
        .front_sel(frontSel)
    );

    frame_buffer #(
        .HOR_ACTIVE_PIXELS(H),
        .VER_ACTIVE_PIXELS(V),
        .FRAMES_PER_SWAP  (3)
    ) dut3 (
        .clk      (clk),
        .rst      (rst3),
        .ce       (ce),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_data  (wrData),
        .frame_end(frameEnd3),
        .rd_en    (rdEn),
        .rd_addr  (rdAddr),
        .rd_data  (rdData3),
        .swap     (swapOut3),
        .front_sel(frontSel3)
    );

    typedef struct {
        int   step;
        logic rd;
        logic sw;
        logic fs;
        logic sw3;
        logic fs3;
    } expT;

    expT expQ[$];

    int compared   = 0;
    int mismatched = 0;
    int stepNum    = 0;

    // Reference state: pixel arrays indexed by bank, the displayed bank, and frames seen.
    bit   modelMem [2][NPIX];
    int   modelFront  = 0;
    int   modelFrames = 0;
    logic modelRd     = 1'b0;
    int   modelFront3  = 0;
    int   modelFrames3 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int step, input logic actual, input logic expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s step=%0d actual=%b required=%b", name, step, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and queues what the outputs must show after the next edge.
    task automatic applyStimulus(input logic ceV, input logic rstV, input logic weV,
                                 input logic [AW-1:0] wa, input logic wd, input logic feV,
                                 input logic reV, input logic [AW-1:0] ra,
                                 input logic rst3V, input logic fe3V);
        expT e;
        bit  swapNow;
        bit  swapNow3;
        @(negedge clk);
        ce = ceV; rst = rstV; wrEn = weV; wrAddr = wa; wrData = wd;
        frameEnd = feV; rdEn = reV; rdAddr = ra; rst3 = rst3V; frameEnd3 = fe3V;
        stepNum++;

        swapNow  = 1'b0;
        swapNow3 = 1'b0;
        if (ceV && weV && int'(wa) < NPIX) modelMem[1 - modelFront][wa] = wd;

        if (rstV) begin
            modelFront  = 0;
            modelFrames = 0;
            modelRd     = 1'b0;
        end else if (ceV) begin
            if (reV) modelRd = (int'(ra) < NPIX) ? modelMem[modelFront][ra] : 1'b0;
            if (feV) begin
                modelFrames++;
                if (modelFrames == 1) begin
                    modelFrames = 0;
                    modelFront  = 1 - modelFront;
                    swapNow     = 1'b1;
                end
            end
        end

        if (rst3V) begin
            modelFront3  = 0;
            modelFrames3 = 0;
        end else if (ceV && fe3V) begin
            modelFrames3++;
            if (modelFrames3 == 3) begin
                modelFrames3 = 0;
                modelFront3  = 1 - modelFront3;
                swapNow3     = 1'b1;
            end
        end

        e.step = stepNum;
        e.rd   = modelRd;
        e.sw   = swapNow;
        e.fs   = modelFront[0];
        e.sw3  = swapNow3;
        e.fs3  = modelFront3[0];
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writePix(input logic [AW-1:0] a, input logic d);
        applyStimulus(1, 0, 1, a, d, 0, 0, 0, 0, 0);
    endtask

    task automatic readPix(input logic [AW-1:0] a);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, a, 0, 0);
    endtask

    task automatic swapFrame();
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rd_data",    e.step, rdData,    e.rd);
                checkOutput("swap",       e.step, swapOut,   e.sw);
                checkOutput("front_sel",  e.step, frontSel,  e.fs);
                checkOutput("swap3",      e.step, swapOut3,  e.sw3);
                checkOutput("front_sel3", e.step, frontSel3, e.fs3);
            end
        end
    end

    initial begin
        int waitCycles;
        ce = 1'b0; rst = 1'b1; rst3 = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = 1'b0;
        frameEnd = 1'b0; frameEnd3 = 1'b0; rdEn = 1'b0; rdAddr = '0;

        // Reset with ce both low and high.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Give both banks known contents.
        for (int i = 0; i < NPIX; i++) writePix(4'(i), 1'($urandom_range(0, 1)));
        swapFrame();
        for (int i = 0; i < NPIX; i++) writePix(4'(i), 1'($urandom_range(0, 1)));
        swapFrame();

        // Single lit pixel stays hidden until the exchange.
        for (int i = 0; i < NPIX; i++) writePix(4'(i), (i == 5) ? 1'b1 : 1'b0);
        readPix(5);
        swapFrame();
        readPix(5);
        idle(1);

        // Out-of-range writes are dropped and out-of-range reads return zero.
        writePix(12, 1);
        writePix(15, 1);
        swapFrame();
        for (int i = 0; i < 13; i++) readPix(4'(i));
        readPix(15);

        // Write coinciding with frame_end lands in the bank about to be shown.
        writePix(3, 0);
        applyStimulus(1, 0, 1, 3, 1, 1, 1, 3, 0, 0);
        applyStimulus(1, 0, 1, 3, 0, 0, 1, 3, 0, 0);
        readPix(3);
        swapFrame();
        readPix(3);

        // Three frames per swap, with a reset after the second pulse.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            idle(1);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Clock enable low freezes everything, then the same inputs with ce high take effect.
        readPix(7);
        applyStimulus(0, 0, 1, 7, 1, 1, 1, 6, 0, 1);
        applyStimulus(0, 0, 1, 6, 1, 1, 1, 6, 0, 1);
        applyStimulus(1, 0, 1, 7, 1, 1, 1, 6, 0, 1);
        readPix(7);
        swapFrame();
        readPix(7);

        // Randomized traffic, including held frame_end and ce gaps.
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 7) != 0,
                          $urandom_range(0, 99) == 0,
                          1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 11) == 0,
                          1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) == 0);
        end
        idle(2);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("scoreboard_drained", stepNum, expQ.size() == 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered 1-bit-per-pixel framebuffer, directly downstream of frame_renderer.
- Absorbs the renderer's pixel write stream (wr_en/wr_addr/wr_data) into the back buffer. Serves scanout reads from the front buffer.
- On a display frame boundary it exchanges the buffers and pulses swap back to the renderer, which starts the next frame.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line.
- VER_ACTIVE_PIXELS, 480, visible lines per frame.
- FRAMES_PER_SWAP, 1, displayed frames per buffer exchange (>=1); caps game frame rate.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when low, no state changes.
- wr_en  input  1  pixel write strobe from renderer.
- wr_addr  input  ADDR_WIDTH  pixel index y*HOR_ACTIVE_PIXELS+x; ADDR_WIDTH=$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS).
- wr_data  input  1  pixel value.
- frame_end  input  1  one-cycle pulse from video timing after the last active pixel of a frame is read.
- rd_en  input  1  scanout read strobe.
- rd_addr  input  ADDR_WIDTH  scanout pixel index.
- rd_data  output  1  pixel value, registered.
- swap  output  1  one-cycle pulse: buffers exchanged, renderer may start the next frame.
- front_sel  output  1  index of the bank currently displayed; debug/LED use.

Behaviour:
- Storage: two banks of HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS bits each, inferred as block RAM: one write port, one read port, no reset of contents.
- Reset values (rst high on a clock edge, regardless of ce): front_sel=0, swap=0, rd_data=0, frame counter=0. Reset mid-frame abandons the counter. Memory contents are kept.
- All state updates below happen only on edges where ce=1. With ce=0, outputs hold, except swap, which is forced 0 after one cycle (it is never high for two consecutive clocks).
- Write path: when wr_en=1 and wr_addr < H*V, bank[~front_sel][wr_addr] <= wr_data. Addresses >= H*V are dropped silently. Writes never touch the front bank.
- Read path: when rd_en=1, rd_data <= (rd_addr < H*V) ? bank[front_sel][rd_addr] : 0, with 1-cycle latency. When rd_en=0, rd_data holds.
- Frame counter: width $clog2(FRAMES_PER_SWAP+1), counts frame_end pulses.
  - On frame_end with counter == FRAMES_PER_SWAP-1: counter <= 0, front_sel <= ~front_sel, swap <= 1 for exactly one cycle.
  - On other frame_end pulses: counter increments, swap stays 0.
- Swap timing: the exchange takes effect on the edge after the frame_end cycle.
  - A write in the same cycle as frame_end goes to the old back bank (the bank about to become front).
  - A read issued in the frame_end cycle returns old-front data.
  - From the cycle swap is high, writes go to the new back bank and reads hit the new front bank.
- No tearing guarantee: no renderer-completion handshake. If the renderer has not finished when swap fires, the partial frame is shown. The renderer is responsible for finishing within the frame period.
- Read and write to the same bank address in the same cycle cannot occur: they are always in different banks.
- frame_end pulses closer than one cycle apart are each counted. A held-high frame_end counts once per ce cycle (caller must pulse).

Test Plan (H=4, V=3, ADDR_WIDTH=4 unless noted):
1. Reset, then rd_en with rd_addr=0..11 -> rd_data=0 after reset for cycle 1; front_sel=0, swap=0.
2. Write wr_data=1 at addr 5 and wr_data=0 elsewhere, then read addr 5 -> 0 (back bank untouched). Then pulse frame_end -> swap high exactly one cycle later, front_sel=1; read addr 5 -> 1 one cycle after rd_en.
3. wr_en with wr_addr=12 and 15, data 1, then swap -> every read of addr 0..11 shows the pre-existing values; addr 12 read returns 0.
4. frame_end and wr_en (addr 3, data 1) in the same cycle -> pixel 3 appears in the newly displayed bank. A write to addr 3 on the swap cycle lands in the new back bank and does not appear until the next swap.
5. FRAMES_PER_SWAP=3: pulse frame_end 6 times -> swap pulses only on the 3rd and 6th; front_sel toggles 0->1->0. Assert rst after the 2nd pulse -> counter restarts, and the next swap comes on the 3rd subsequent pulse.
6. ce=0 while frame_end, wr_en and rd_en are asserted -> no write, rd_data holds, front_sel unchanged, no swap. The same stimulus with ce=1 takes effect.
